vcdl_delay_servo: RTL and testbench
===================================

# vcdl_delay_servo

Calibration servo that drives the 5-bit delay-load interface of the VCDL delay stage and consumes its feedback sample output. On command it scans all 32 taps and integrates the feedback sample at each tap. It locates the first low→high transition of the delayed VCDL as seen by the feedback clock, then loads the final tap (edge + offset). It also passes through manual delay loads while idle.

## Interface
- SETTLE_CYCLES, 16, cycles waited after each tap load before sampling; must be ≥3.
- SAMPLES, 64, feedback samples integrated per tap; power of two, 8..256.
- OFFSET, 0, taps added to the detected edge tap; 0..31; sum saturates at 31.
- clk_i  in  1  single clock; same clock as the VCDL delay_clk_i.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; starts a scan when idle.
- manual_delay_i  in  5  manual tap value.
- manual_ld_i  in  1  one-cycle pulse; loads manual_delay_i when idle.
- vcdl_fb_q_i  in  1  VCDL feedback sample; asynchronous to clk_i; double-registered internally.
- delay_o  out  5  tap value to the VCDL delay_i.
- delay_ld_o  out  1  one-cycle load strobe to the VCDL delay_ld_i.
- busy_o  out  1  high while scanning (LOAD..APPLY).
- done_o  out  1  one-cycle pulse at scan completion.
- locked_o  out  1  last scan found an edge and its tap is applied.
- fail_o  out  1  last scan found no edge.
- edge_tap_o  out  5  detected edge tap from the last successful scan.

## Operation
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE.
- IDLE:
  - manual_ld_i → held := manual_delay_i; issue load; clear locked_o and fail_o.
  - Otherwise start_i → tap := 0; last_class := NONE; clear locked_o and fail_o; go to LOAD.
  - manual_ld_i has priority over a simultaneous start_i; that start is dropped.
- LOAD: delay_o := tap, delay_ld_o high for this cycle only → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE. This also flushes the 2-flop synchronizer.
- SAMPLE: for SAMPLES cycles, ones += synchronized fb. The ones counter is log2(SAMPLES)+1 bits wide and cleared in LOAD.
- EVAL, classification of the tap:
  - HIGH if ones ≥ SAMPLES − SAMPLES/4.
  - LOW if ones ≤ SAMPLES/4.
  - Otherwise AMBIG.
- EVAL, next state:
  - If HIGH and last_class = LOW → edge found; edge_tap_o := tap; go to APPLY with target = min(tap+OFFSET, 31).
  - Otherwise, if the class is not AMBIG, last_class := class. AMBIG never updates last_class.
  - If tap = 31 → APPLY with target = held (fail).
  - Else tap := tap+1 → LOAD.
- APPLY: delay_o := target; delay_ld_o high for one cycle. On success held := target → DONE.
- DONE (1 cycle):
  - done_o = 1.
  - locked_o := success, fail_o := !success; both persist until the next start or manual load.
  - Next state IDLE.
- start_i and manual_ld_i are ignored when not in IDLE.
- delay_o is registered and holds its last value between strobes.
- delay_ld_o is never asserted for more than one consecutive cycle.

## Timing
- Reset values: delay_o=0, delay_ld_o=0, busy_o=0, done_o=0, locked_o=0, fail_o=0, edge_tap_o=0, held=0, state IDLE.
- Reset mid-scan:
  - All outputs return to reset values immediately.
  - No load strobe is issued; the VCDL keeps its last loaded tap.
- Cycle numbering: cycle k is the cycle after clock edge k; start_i is sampled at edge 0.
- Per-tap period is P = SETTLE_CYCLES + SAMPLES + 2 (LOAD + SETTLE + SAMPLE + EVAL).
- Tap t's load strobe is in cycle 1 + t·P.
- If the scan ends after T taps evaluated:
  - APPLY strobe is in cycle 1 + T·P.
  - DONE (done_o) is in cycle 2 + T·P.
  - locked_o/fail_o are valid from cycle 2 + T·P.
- busy_o is high from cycle 1 through cycle 1 + T·P inclusive.
- Manual load: manual_ld_i sampled at edge 0 → delay_ld_o and the new delay_o in cycle 1.
- The synchronizer adds 2 cycles of latency on vcdl_fb_q_i; SETTLE_CYCLES ≥ 3 guarantees no stale samples.

## Test plan
All scenarios use defaults (P=82).
- Reset: assert rst_n_i=0 at arbitrary time → all outputs 0 asynchronously. No delay_ld_o during or after release.
- Clean edge: model fb=1 iff loaded tap ≥12; pulse start_i → 13 load strobes at cycles 1+82t (t=0..12), APPLY strobe at cycle 1067 with delay_o=12, done_o at 1068, locked_o=1, edge_tap_o=12.
- Offset saturation: OFFSET=4, edge at tap 30 → APPLY delay_o=31, locked_o=1, edge_tap_o=30.
- Ambiguous taps:
  - fb random 50% at taps 10–11, 1 for taps ≥12 → edge_tap_o=12.
  - fb constant 1 → no LOW ever seen → 32 taps, fail_o=1, APPLY delay_o=held, done_o at cycle 2+32·82=2626.
- Manual/priority:
  - manual_ld_i with value 7 while idle → delay_o=7, strobe in cycle 1.
  - manual_ld_i and start_i in the same cycle → manual load only, busy_o stays 0.
  - manual_ld_i or start_i during a scan → no effect on strobes or results.
  - After a failing scan → delay_o=7.
- Reset mid-scan: rst_n_i low during tap 5 SAMPLE → outputs reset. A fresh start_i then completes the clean-edge case with identical cycle timing.

Source files
------------

// File: rtl/vcdl_delay_servo.sv
// rtl/vcdl_delay_servo.sv - VCDL calibration servo: 32-tap edge scan, offset apply, manual load pass-through
module vcdl_delay_servo #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 64,
  parameter int OFFSET        = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [4:0] manual_delay_i,
  input  logic       manual_ld_i,
  input  logic       vcdl_fb_q_i,
  output logic [4:0] delay_o,
  output logic       delay_ld_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [4:0] edge_tap_o
);

  localparam int OW   = $clog2(SAMPLES) + 1;
  localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [OW-1:0] HI_TH       = OW'(SAMPLES - SAMPLES / 4);
  localparam logic [OW-1:0] LO_TH       = OW'(SAMPLES / 4);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
  localparam logic [5:0]    OFF6        = 6'(OFFSET);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_DONE
  } state_e;

  typedef enum logic [1:0] {C_NONE, C_LOW, C_HIGH, C_AMBIG} class_e;

  state_e        state_q;
  class_e        last_class_q;
  class_e        tap_class;
  logic [4:0]    tap_q;
  logic [4:0]    held_q;
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] ones_q;
  logic          success_q;
  logic          fb_meta_q, fb_sync_q;
  logic [4:0]    delay_q;
  logic          delay_ld_q, busy_q, done_q, locked_q, fail_q;
  logic [4:0]    edge_tap_q;
  logic [5:0]    edge_sum;
  logic [4:0]    edge_target;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fb_meta_q <= 1'b0;
      fb_sync_q <= 1'b0;
    end else begin
      fb_meta_q <= vcdl_fb_q_i;
      fb_sync_q <= fb_meta_q;
    end
  end

  always_comb begin
    tap_class = C_AMBIG;
    if (ones_q >= HI_TH)      tap_class = C_HIGH;
    else if (ones_q <= LO_TH) tap_class = C_LOW;
  end

  assign edge_sum    = {1'b0, tap_q} + OFF6;
  assign edge_target = edge_sum[5] ? 5'd31 : edge_sum[4:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      last_class_q <= C_NONE;
      tap_q        <= '0;
      held_q       <= '0;
      cnt_q        <= '0;
      ones_q       <= '0;
      success_q    <= 1'b0;
      delay_q      <= '0;
      delay_ld_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      edge_tap_q   <= '0;
    end else begin
      delay_ld_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A request in the cycle right after a strobe waits, keeping strobes single-cycle.
          if (!delay_ld_q) begin
            if (manual_ld_i) begin
              delay_q    <= manual_delay_i;
              delay_ld_q <= 1'b1;
              held_q     <= manual_delay_i;
              locked_q   <= 1'b0;
              fail_q     <= 1'b0;
            end else if (start_i) begin
              tap_q        <= '0;
              last_class_q <= C_NONE;
              locked_q     <= 1'b0;
              fail_q       <= 1'b0;
              delay_q      <= '0;
              delay_ld_q   <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          ones_q  <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SAMPLE: begin
          ones_q <= ones_q + {{(OW-1){1'b0}}, fb_sync_q};
          if (cnt_q == SAMPLE_LAST) state_q <= S_EVAL;
          else                      cnt_q   <= cnt_q + CW'(1);
        end
        S_EVAL: begin
          if (tap_class == C_HIGH && last_class_q == C_LOW) begin
            edge_tap_q <= tap_q;
            success_q  <= 1'b1;
            delay_q    <= edge_target;
            delay_ld_q <= 1'b1;
            state_q    <= S_APPLY;
          end else begin
            if (tap_class != C_AMBIG) last_class_q <= tap_class;
            delay_ld_q <= 1'b1;
            if (tap_q == 5'd31) begin
              success_q <= 1'b0;
              delay_q   <= held_q;
              state_q   <= S_APPLY;
            end else begin
              tap_q   <= tap_q + 5'd1;
              delay_q <= tap_q + 5'd1;
              state_q <= S_LOAD;
            end
          end
        end
        S_APPLY: begin
          if (success_q) held_q <= delay_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          locked_q <= success_q;
          fail_q   <= !success_q;
          state_q  <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign delay_o    = delay_q;
  assign delay_ld_o = delay_ld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign locked_o   = locked_q;
  assign fail_o     = fail_q;
  assign edge_tap_o = edge_tap_q;

endmodule

// File: tb/tb_vcdl_delay_servo.sv
// tb/tb_vcdl_delay_servo.sv - self-checking bench for vcdl_delay_servo (OFFSET=0 and OFFSET=4 instances)
module tb_vcdl_delay_servo;

  localparam int P = 82;

  logic       clk = 1'b0;
  logic       rst_n, start, mld, fb;
  logic [4:0] mdel;
  logic [4:0] d0, d4, edge0, edge4;
  logic       ld0, ld4, busy0, busy4, done0, done4, lock0, lock4, fail0, fail4;

  int errors = 0;
  int checks = 0;
  int prof[32];
  int vtap = 0;
  int held0 = 0, held4 = 0, last_edge = 0;

  typedef struct {
    int hi_from; int amb_lo; int amb_hi;
    int exp_t; bit exp_ok; int exp_edge; int exp_d0; int exp_d4; int inj_k;
  } scan_vec_t;
  scan_vec_t vecs[6];

  vcdl_delay_servo dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .manual_delay_i(mdel),
    .manual_ld_i(mld), .vcdl_fb_q_i(fb), .delay_o(d0), .delay_ld_o(ld0),
    .busy_o(busy0), .done_o(done0), .locked_o(lock0), .fail_o(fail0), .edge_tap_o(edge0)
  );

  vcdl_delay_servo #(.OFFSET(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .manual_delay_i(mdel),
    .manual_ld_i(mld), .vcdl_fb_q_i(fb), .delay_o(d4), .delay_ld_o(ld4),
    .busy_o(busy4), .done_o(done4), .locked_o(lock4), .fail_o(fail4), .edge_tap_o(edge4)
  );

  always #5 clk = ~clk;

  // VCDL stand-in: latches the tap on a strobe, feedback follows the per-tap profile
  always @(posedge clk) if (ld0) vtap = int'(d0);
  always @(negedge clk) begin
    if (prof[vtap] == 2) fb = ($urandom % 2) == 1;
    else                 fb = (prof[vtap] == 1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_profile(input int hi_from, input int amb_lo, input int amb_hi);
    for (int t = 0; t < 32; t++)
      prof[t] = (t >= amb_lo && t <= amb_hi) ? 2 : ((t >= hi_from) ? 1 : 0);
  endtask

  // Scan rules: first HIGH whose latest non-ambiguous predecessor was LOW
  function automatic void model_scan(output int t_n, output bit ok, output int etap,
                                     output int tg0, output int tg4);
    int last = -1;
    ok = 1'b0; t_n = 32; etap = last_edge; tg0 = held0; tg4 = held4;
    for (int t = 0; t < 32; t++) begin
      if (prof[t] == 1 && last == 0) begin
        ok = 1'b1; t_n = t + 1; etap = t; tg0 = t; tg4 = (t + 4 > 31) ? 31 : t + 4;
        break;
      end
      if (prof[t] != 2) last = prof[t];
    end
  endfunction

  task automatic manual_load(input string tag, input int val, input bit with_start);
    int extra = 0, busy_seen = 0;
    @(negedge clk); mdel = 5'(val); mld = 1'b1; start = with_start;
    @(negedge clk); mld = 1'b0; start = 1'b0;
    chk({tag, ".strobe"}, int'(ld0), 1);
    chk({tag, ".delay"}, int'(d0), val);
    chk({tag, ".locked_clr"}, int'(lock0 | fail0), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ld0) extra++;
      if (busy0 | busy4) busy_seen++;
    end
    chk({tag, ".extra_strobes"}, extra, 0);
    chk({tag, ".busy"}, busy_seen, 0);
    held0 = val; held4 = val;
  endtask

  task automatic run_scan(input string tag, input int e_t, input bit e_ok, input int e_edge,
                          input int e_d0, input int e_d4, input int inj_k);
    int sc[$], sv[$];
    int ap4 = -1, n4 = 0, first_busy = -1, last_busy = -1;
    int done_cnt = 0, done_cyc = -1, consec = 0, bad = 0;
    int lock_at = -1, fail_at = -1, lock4_at = -1, edge_at = -1;
    bit prev0 = 1'b0, prev4 = 1'b0;
    int k = 1, end_k = 3000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (k < end_k) begin
      if (k == inj_k) begin start = 1'b1; mld = 1'b1; mdel = 5'd3; end
      else if (k == inj_k + 1) begin start = 1'b0; mld = 1'b0; end
      if (ld0) begin sc.push_back(k); sv.push_back(int'(d0)); end
      if (ld4) begin n4++; ap4 = int'(d4); end
      if ((ld0 && prev0) || (ld4 && prev4)) consec++;
      prev0 = ld0; prev4 = ld4;
      if (busy0) begin if (first_busy < 0) first_busy = k; last_busy = k; end
      if (done0) begin
        done_cnt++; done_cyc = k; end_k = k + 3;
        lock_at = int'(lock0); fail_at = int'(fail0); lock4_at = int'(lock4); edge_at = int'(edge0);
      end
      @(negedge clk); k++;
    end
    start = 1'b0; mld = 1'b0;
    foreach (sc[i]) begin
      if (sc[i] != 1 + i * P) bad++;
      if (i < e_t && sv[i] != i) bad++;
    end
    chk({tag, ".strobe_count"}, sc.size(), e_t + 1);
    chk({tag, ".strobe_timing"}, bad, 0);
    chk({tag, ".apply_d0"}, (sc.size() > 0) ? sv[sc.size() - 1] : -1, e_d0);
    chk({tag, ".apply_d4"}, ap4, e_d4);
    chk({tag, ".strobe_count4"}, n4, e_t + 1);
    chk({tag, ".done_cycle"}, done_cyc, 2 + e_t * P);
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".busy_first"}, first_busy, 1);
    chk({tag, ".busy_last"}, last_busy, 1 + e_t * P);
    chk({tag, ".locked"}, lock_at, int'(e_ok));
    chk({tag, ".fail"}, fail_at, int'(!e_ok));
    chk({tag, ".locked4"}, lock4_at, int'(e_ok));
    chk({tag, ".edge_tap"}, edge_at, e_edge);
    chk({tag, ".consec_strobe"}, consec, 0);
    chk({tag, ".delay_hold"}, int'(d0), e_d0);
    chk({tag, ".locked_persist"}, int'(lock0), int'(e_ok));
    held0 = e_d0; held4 = e_d4;
    if (e_ok) last_edge = e_edge;
  endtask

  initial begin
    int t_n, etap, tg0, tg4;
    bit ok;
    int strobes;

    vecs[0] = '{0, 40, 40, 32, 1'b0, 0, 7, 7, -1};
    vecs[1] = '{12, 40, 40, 13, 1'b1, 12, 12, 16, 500};
    vecs[2] = '{30, 40, 40, 31, 1'b1, 30, 30, 31, -1};
    vecs[3] = '{12, 10, 11, 13, 1'b1, 12, 12, 16, -1};
    vecs[4] = '{32, 40, 40, 32, 1'b0, 12, 12, 16, -1};
    vecs[5] = '{1, 40, 40, 2, 1'b1, 1, 1, 5, -1};

    rst_n = 1'b0; start = 1'b0; mld = 1'b0; mdel = '0; fb = 1'b0;
    set_profile(32, 40, 40);
    repeat (3) @(negedge clk);
    chk("reset.outputs", int'({d0, ld0, busy0, done0, lock0, fail0, edge0}), 0);
    chk("reset.outputs4", int'({d4, ld4, busy4, done4, lock4, fail4, edge4}), 0);
    rst_n = 1'b1;

    manual_load("man_start", 9, 1'b1);
    manual_load("man7", 7, 1'b0);

    foreach (vecs[i]) begin
      set_profile(vecs[i].hi_from, vecs[i].amb_lo, vecs[i].amb_hi);
      run_scan($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_ok, vecs[i].exp_edge,
               vecs[i].exp_d0, vecs[i].exp_d4, vecs[i].inj_k);
    end

    // Asynchronous reset in the middle of tap 5's sample window
    set_profile(12, 40, 40);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (437) @(negedge clk);
    chk("midrst.busy_before", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.outputs", int'({d0, ld0, busy0, done0, lock0, fail0, edge0}), 0);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ld0 | ld4) strobes++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("midrst.no_strobe", strobes, 0);
    chk("midrst.vcdl_tap_kept", vtap, 5);
    held0 = 0; held4 = 0; last_edge = 0;
    run_scan("after_rst", 13, 1'b1, 12, 12, 16, -1);

    for (int r = 0; r < 4; r++) begin
      manual_load($sformatf("rnd%0d.man", r), int'($urandom_range(0, 31)), 1'b0);
      for (int t = 0; t < 32; t++) prof[t] = int'($urandom_range(0, 2));
      model_scan(t_n, ok, etap, tg0, tg4);
      run_scan($sformatf("rnd%0d", r), t_n, ok, etap, tg0, tg4, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
